sram_arb: RTL
=============

# sram_arb

Fixed-slot arbiter that shares the single SDRAM-backed `sram` controller between three requesters: video fetch, CPU (Wishbone side), and the memory-copy/loader engine. It sits between those requesters and the `sram` instance. The `sram` controller has no ready or ack output, so this block drives its level-sensitive `rd`/`we` strobes for a fixed window, samples `dout`, and returns a one-cycle ack to the winner. Priority is video > CPU > copy, with a starvation guard that lets copy outrank the CPU.

## Interface
Parameters:
- `SLOT_CYCLES`, default 20: clk_ram cycles the strobe is held per access. Must cover the `sram` worst case: 2-cycle edge sync, 7-cycle refresh, open, and CAS delay (about 18 at 112 MHz).
- `GAP_CYCLES`, default 2: strobe-low cycles after each slot. Must be ≥2 so the `sram` edge detector sees a falling edge.
- `STARVE_MAX`, default 4: number of consecutive CPU grants taken while copy is pending before copy outranks the CPU.

Ports:
- `clk_ram` in 1: SDRAM-domain clock, the only clock.
- `init` in 1: reset, asynchronous, active-high.
- `vid_addr` in 24: video word address. `vid_stb` in 1: video read request. `vid_ack` out 1: one-cycle ack. `vid_dout` out 16: video read data.
- `cpu_addr` in 24, `cpu_din` in 16, `cpu_wtbt` in 2, `cpu_we` in 1, `cpu_stb` in 1: CPU request. `cpu_ack` out 1, `cpu_dout` out 16.
- `cpy_addr` in 24, `cpy_din` in 16, `cpy_we` in 1, `cpy_stb` in 1: copy request; byte mask is fixed at 2'b11. `cpy_ack` out 1, `cpy_dout` out 16.
- `ram_addr` out 24, `ram_din` out 16, `ram_wtbt` out 2, `ram_we` out 1, `ram_rd` out 1: drive the `sram` inputs.
- `ram_dout` in 16: `sram` data output.
- `grant` out 2: current owner. 0 = none, 1 = video, 2 = CPU, 3 = copy.
- `busy` out 1: high in SLOT and GAP.

## Operation
Reset values (`init` high, asynchronous): all of the following are 0:
- state IDLE, `grant`, `busy`, `ram_rd`, `ram_we`, `ram_addr`, `ram_din`, `ram_wtbt`
- all acks and all douts
- slot counter, gap counter, `skip_cnt`

Request rules:
- A requester holds `stb` high with stable address, data and `we` until its ack.
- Video is read-only.

State machine:
- **IDLE**
  - Pick a winner among requesters with `stb` high.
  - Order is video, then CPU, then copy.
  - Exception: if `skip_cnt` == `STARVE_MAX` and `cpy_stb` is high, copy beats the CPU. Video always wins.
  - On a grant:
    - Register the winner's address, data and mask into `ram_*`. Mask is the CPU's `cpu_wtbt`; video and copy use 2'b11.
    - Set `ram_rd` = !we or `ram_we` = we, set `grant`, load the slot counter, go to SLOT.
  - With no `stb` high, stay in IDLE with all outputs unchanged.
- **SLOT**
  - Strobe and `ram_*` are held constant; counter decrements.
  - On the last cycle:
    - Pulse the winner's ack if its `stb` is still high.
    - For a read, latch `ram_dout` into that port's dout.
    - Go to GAP.
  - If `stb` dropped mid-slot, the access still completes, but there is no ack and no dout update.
- **GAP**
  - `ram_rd` = `ram_we` = 0; `ram_addr`/`ram_din` hold.
  - After `GAP_CYCLES` cycles, `grant` returns to 0 and the state returns to IDLE.

`skip_cnt` (saturating at `STARVE_MAX`) updates at grant time:
- +1 on a CPU grant while `cpy_stb` is high.
- Reset to 0 on a copy grant.
- Unchanged on a video grant.

Each dout holds its value until that port's next completed read. A write never changes any dout.

## Timing
- Request visible at edge t in IDLE → strobe high over cycles t+1 … t+`SLOT_CYCLES`.
- Ack and dout are valid in cycle t+`SLOT_CYCLES`.
- Back-to-back period is `SLOT_CYCLES` + `GAP_CYCLES` + 1 = 23 cycles at defaults.
- A requester sampling `stb` still high in the cycle after its ack is treated as a new request; it may win again at the next IDLE.
- Simultaneous `stb` assertions are resolved only in IDLE. A new higher-priority request never preempts an active slot.
- `init` asserted mid-slot forces IDLE immediately with all outputs zeroed. The `sram` controller is re-initialised by its own reset path.
- `ram_*` change only on the IDLE→SLOT edge, so there are no glitches while a strobe is high.

## Test plan
- Single CPU read: `cpu_addr`=0x001234, `sram` model returns 0xBEEF → `ram_rd` high for 20 cycles, `cpu_ack` one pulse at cycle 20, `cpu_dout`=0xBEEF.
- CPU write: `cpu_din`=0x55AA, `cpu_wtbt`=2'b01 → `ram_we`=1, `ram_wtbt`=2'b01, `ram_din`=0x55AA for 20 cycles, ack at cycle 20, `cpu_dout` unchanged.
- All three `stb` raised in the same cycle → grant order video, CPU, copy; acks spaced 23 cycles apart.
- CPU and copy both held high continuously → 4 CPU grants, then 1 copy grant; `skip_cnt` returns to 0 and the pattern repeats.
- `cpu_stb` dropped at slot cycle 5 → strobe still held for 20 cycles, no `cpu_ack`, `cpu_dout` unchanged, then GAP and IDLE.
- `init` pulsed at slot cycle 10 → `ram_rd`, `grant` and `busy` are 0 in the same cycle; a pending video request is granted 1 cycle after release.

Source files
------------

// File: rtl/sram_arb.sv
// Fixed-slot arbiter sharing one ack-less sram controller between video, CPU and copy.
// Each grant holds the strobe for SLOT_CYCLES, drops it for GAP_CYCLES, then re-arbitrates.
module sram_arb #(
  parameter int SLOT_CYCLES = 20,
  parameter int GAP_CYCLES  = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk_ram,
  input  logic        init,
  input  logic [23:0] vid_addr,
  input  logic        vid_stb,
  output logic        vid_ack,
  output logic [15:0] vid_dout,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_wtbt,
  input  logic        cpu_we,
  input  logic        cpu_stb,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
  input  logic [23:0] cpy_addr,
  input  logic [15:0] cpy_din,
  input  logic        cpy_we,
  input  logic        cpy_stb,
  output logic        cpy_ack,
  output logic [15:0] cpy_dout,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [1:0]  ram_wtbt,
  output logic        ram_we,
  output logic        ram_rd,
  input  logic [15:0] ram_dout,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam int SW = $clog2(SLOT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int KW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, SLOT, GAP} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    grant_reg, grant_next;
  logic          busy_reg, busy_next;
  logic          ram_rd_reg, ram_rd_next;
  logic          ram_we_reg, ram_we_next;
  logic [23:0]   ram_addr_reg, ram_addr_next;
  logic [15:0]   ram_din_reg, ram_din_next;
  logic [1:0]    ram_wtbt_reg, ram_wtbt_next;
  logic          vid_ack_reg, vid_ack_next;
  logic          cpu_ack_reg, cpu_ack_next;
  logic          cpy_ack_reg, cpy_ack_next;
  logic [15:0]   vid_dout_reg, vid_dout_next;
  logic [15:0]   cpu_dout_reg, cpu_dout_next;
  logic [15:0]   cpy_dout_reg, cpy_dout_next;
  logic [SW-1:0] slot_cnt_reg, slot_cnt_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic [KW-1:0] skip_cnt_reg, skip_cnt_next;
  logic          starved;

  // Copy outranks the CPU only once the CPU has taken STARVE_MAX grants past it.
  assign starved = cpy_stb && (skip_cnt_reg == KW'(STARVE_MAX));

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    busy_next     = busy_reg;
    ram_rd_next   = ram_rd_reg;
    ram_we_next   = ram_we_reg;
    ram_addr_next = ram_addr_reg;
    ram_din_next  = ram_din_reg;
    ram_wtbt_next = ram_wtbt_reg;
    vid_ack_next  = 1'b0;
    cpu_ack_next  = 1'b0;
    cpy_ack_next  = 1'b0;
    vid_dout_next = vid_dout_reg;
    cpu_dout_next = cpu_dout_reg;
    cpy_dout_next = cpy_dout_reg;
    slot_cnt_next = slot_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    skip_cnt_next = skip_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (vid_stb || cpu_stb || cpy_stb) begin
          state_next    = SLOT;
          busy_next     = 1'b1;
          slot_cnt_next = SW'(SLOT_CYCLES - 1);
          if (vid_stb) begin
            grant_next    = 2'd1;
            ram_addr_next = vid_addr;
            ram_din_next  = 16'h0000;
            ram_wtbt_next = 2'b11;
            ram_rd_next   = 1'b1;
            ram_we_next   = 1'b0;
          end else if (cpu_stb && !starved) begin
            grant_next    = 2'd2;
            ram_addr_next = cpu_addr;
            ram_din_next  = cpu_din;
            ram_wtbt_next = cpu_wtbt;
            ram_rd_next   = !cpu_we;
            ram_we_next   = cpu_we;
            if (cpy_stb && skip_cnt_reg != KW'(STARVE_MAX))
              skip_cnt_next = skip_cnt_reg + KW'(1);
          end else begin
            grant_next    = 2'd3;
            ram_addr_next = cpy_addr;
            ram_din_next  = cpy_din;
            ram_wtbt_next = 2'b11;
            ram_rd_next   = !cpy_we;
            ram_we_next   = cpy_we;
            skip_cnt_next = '0;
          end
        end
      end
      SLOT: begin
        if (slot_cnt_reg == '0) begin
          state_next   = GAP;
          ram_rd_next  = 1'b0;
          ram_we_next  = 1'b0;
          gap_cnt_next = GW'(GAP_CYCLES - 1);
        end else begin
          slot_cnt_next = slot_cnt_reg - SW'(1);
          // Registered ack/dout become visible in the final strobe cycle.
          if (slot_cnt_reg == SW'(1)) begin
            case (grant_reg)
              2'd1: if (vid_stb) begin
                vid_ack_next = 1'b1;
                if (ram_rd_reg) vid_dout_next = ram_dout;
              end
              2'd2: if (cpu_stb) begin
                cpu_ack_next = 1'b1;
                if (ram_rd_reg) cpu_dout_next = ram_dout;
              end
              2'd3: if (cpy_stb) begin
                cpy_ack_next = 1'b1;
                if (ram_rd_reg) cpy_dout_next = ram_dout;
              end
              default: ;
            endcase
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
          grant_next = 2'd0;
          busy_next  = 1'b0;
        end else begin
          gap_cnt_next = gap_cnt_reg - GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_ram or posedge init) begin
    if (init) begin
      state_reg    <= IDLE;
      grant_reg    <= 2'd0;
      busy_reg     <= 1'b0;
      ram_rd_reg   <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      ram_wtbt_reg <= 2'b00;
      vid_ack_reg  <= 1'b0;
      cpu_ack_reg  <= 1'b0;
      cpy_ack_reg  <= 1'b0;
      vid_dout_reg <= '0;
      cpu_dout_reg <= '0;
      cpy_dout_reg <= '0;
      slot_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      skip_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      busy_reg     <= busy_next;
      ram_rd_reg   <= ram_rd_next;
      ram_we_reg   <= ram_we_next;
      ram_addr_reg <= ram_addr_next;
      ram_din_reg  <= ram_din_next;
      ram_wtbt_reg <= ram_wtbt_next;
      vid_ack_reg  <= vid_ack_next;
      cpu_ack_reg  <= cpu_ack_next;
      cpy_ack_reg  <= cpy_ack_next;
      vid_dout_reg <= vid_dout_next;
      cpu_dout_reg <= cpu_dout_next;
      cpy_dout_reg <= cpy_dout_next;
      slot_cnt_reg <= slot_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      skip_cnt_reg <= skip_cnt_next;
    end
  end

  assign grant    = grant_reg;
  assign busy     = busy_reg;
  assign ram_rd   = ram_rd_reg;
  assign ram_we   = ram_we_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_din  = ram_din_reg;
  assign ram_wtbt = ram_wtbt_reg;
  assign vid_ack  = vid_ack_reg;
  assign cpu_ack  = cpu_ack_reg;
  assign cpy_ack  = cpy_ack_reg;
  assign vid_dout = vid_dout_reg;
  assign cpu_dout = cpu_dout_reg;
  assign cpy_dout = cpy_dout_reg;

endmodule
